// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decode queue bus: fetch return beats in, decode head entry out.
// The fetch side (master) drives beats and flush; the queue (slave) drives the head entry and status.
interface inst_fetch_queue_if #(
    parameter int DEPTH = 4
);
    logic                       in_valid;
    logic [31:0]                in_inst;
    logic [31:0]                in_pc;
    logic                       in_flight;
    logic                       flush;
    logic                       out_ready;
    logic                       out_valid;
    logic [31:0]                out_inst;
    logic [31:0]                out_pc;
    logic [$clog2(DEPTH):0]     count;
    logic                       stall_fetch;
    logic                       overflow;

    modport master (
        output in_valid,
        output in_inst,
        output in_pc,
        output in_flight,
        output flush,
        output out_ready,
        input  out_valid,
        input  out_inst,
        input  out_pc,
        input  count,
        input  stall_fetch,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  in_inst,
        input  in_pc,
        input  in_flight,
        input  flush,
        input  out_ready,
        output out_valid,
        output out_inst,
        output out_pc,
        output count,
        output stall_fetch,
        output overflow
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry circular buffer of {pc, inst} with flush/drop tracking.
// Optional same-cycle bypass of an empty queue is enabled by defining FETCH_QUEUE_BYPASS_EN.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal operation, returned beats are pushed
// DROP  | a request issued before a flush is still outstanding; discard its beat
module inst_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    inst_fetch_queue_if.slave    bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        RUN  = 1'b0,
        DROP = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [63:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            overflow_q;

    logic            empty;
    logic            full;
    logic            bypass_hit;
    logic            push_req;
    logic            do_push;
    logic            do_pop;
    logic            ovf_set;
    logic [63:0]     head;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign head  = mem[rd_ptr];

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit = empty && (state == RUN) && bus.in_valid && !bus.flush;
`else
    assign bypass_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A flush always discards the same-cycle beat; DROP covers a beat still in flight.
    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        do_pop    = 1'b0;
        do_push   = 1'b0;
        ovf_set   = 1'b0;

        case (state)
            RUN: begin
                if (bus.flush) begin
                    state_nxt = bus.in_flight ? DROP : RUN;
                end else begin
                    push_req = bus.in_valid;
                end
            end
            DROP: begin
                if (bus.flush) begin
                    state_nxt = DROP;
                end else if (bus.in_valid || !bus.in_flight) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase

        do_pop  = !empty && bus.out_ready && !bus.flush;
        // A bypassed beat taken by decode in the same cycle never enters storage.
        do_push = push_req && !(bypass_hit && bus.out_ready) && (!full || do_pop);
        ovf_set = push_req && full && !do_pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   cnt <= cnt + CW'(1);
                    2'b01:   cnt <= cnt - CW'(1);
                    default: cnt <= cnt;
                endcase
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; entries are only visible through cnt.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= {bus.in_pc, bus.in_inst};
        end
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_inst  = '0;
        bus.out_pc    = '0;
        if (bypass_hit) begin
            bus.out_valid = 1'b1;
            bus.out_inst  = bus.in_inst;
            bus.out_pc    = bus.in_pc;
        end else if (!empty) begin
            bus.out_valid = 1'b1;
            bus.out_inst  = head[31:0];
            bus.out_pc    = head[63:32];
        end
    end

    assign bus.count       = cnt;
    assign bus.stall_fetch = (cnt >= CW'(DEPTH - 1));
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (DEPTH=4) with hand-computed expectations.
// Bypass-dependent expectations follow FETCH_QUEUE_BYPASS_EN.
module tb_inst_fetch_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    inst_fetch_queue_if #(.DEPTH(4)) bus ();

    inst_fetch_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic push(input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        bus.in_flight = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_inst", 64'(bus.out_inst), 64'd0);
        chk("rst_pc", 64'(bus.out_pc), 64'd0);
        chk("rst_stall", 64'(bus.stall_fetch), 64'd0);
        chk("rst_ovf", 64'(bus.overflow), 64'd0);

        // first push, latency one cycle
        push(32'h2402_0001, 32'hBFC0_0000);
        chk("p1_valid", 64'(bus.out_valid), 64'd1);
        chk("p1_inst", 64'(bus.out_inst), 64'h2402_0001);
        chk("p1_pc", 64'(bus.out_pc), 64'hBFC0_0000);
        chk("p1_count", 64'(bus.count), 64'd1);
        chk("p1_stall", 64'(bus.stall_fetch), 64'd0);

        push(32'h0000_1002, 32'hBFC0_0004);
        chk("p2_count", 64'(bus.count), 64'd2);
        chk("p2_stall", 64'(bus.stall_fetch), 64'd0);
        push(32'h0000_1003, 32'hBFC0_0008);
        chk("p3_count", 64'(bus.count), 64'd3);
        chk("p3_stall", 64'(bus.stall_fetch), 64'd1);
        push(32'h0000_1004, 32'hBFC0_000C);
        chk("p4_count", 64'(bus.count), 64'd4);
        chk("p4_stall", 64'(bus.stall_fetch), 64'd1);
        chk("p4_ovf", 64'(bus.overflow), 64'd0);
        push(32'h0000_1005, 32'hBFC0_0010);
        chk("ovf_count", 64'(bus.count), 64'd4);
        chk("ovf_flag", 64'(bus.overflow), 64'd1);
        chk("ovf_head", 64'(bus.out_inst), 64'h2402_0001);
        tick();
        chk("ovf_sticky", 64'(bus.overflow), 64'd1);

        do_reset();
        chk("rst2_ovf", 64'(bus.overflow), 64'd0);
        chk("rst2_count", 64'(bus.count), 64'd0);

        // full queue, simultaneous push and pop
        push(32'h0000_2001, 32'h0000_0100);
        push(32'h0000_2002, 32'h0000_0104);
        push(32'h0000_2003, 32'h0000_0108);
        push(32'h0000_2004, 32'h0000_010C);
        chk("full_count", 64'(bus.count), 64'd4);
        bus.out_ready = 1'b1;
        push(32'h0000_2005, 32'h0000_0110);
        chk("pp_count", 64'(bus.count), 64'd4);
        chk("pp_head", 64'(bus.out_inst), 64'h0000_2002);
        chk("pp_ovf", 64'(bus.overflow), 64'd0);
        tick();
        chk("drain1_inst", 64'(bus.out_inst), 64'h0000_2003);
        chk("drain1_pc", 64'(bus.out_pc), 64'h0000_0108);
        tick();
        chk("drain2_inst", 64'(bus.out_inst), 64'h0000_2004);
        tick();
        chk("drain3_inst", 64'(bus.out_inst), 64'h0000_2005);
        chk("drain3_pc", 64'(bus.out_pc), 64'h0000_0110);
        chk("drain3_count", 64'(bus.count), 64'd1);
        tick();
        chk("empty_count", 64'(bus.count), 64'd0);
        chk("empty_valid", 64'(bus.out_valid), 64'd0);
        chk("empty_inst", 64'(bus.out_inst), 64'd0);
        tick();
        chk("pop_empty", 64'(bus.count), 64'd0);
        bus.out_ready = 1'b0;

        // flush with a request in flight, its beat is dropped
        push(32'h0000_3001, 32'h0000_0200);
        push(32'h0000_3002, 32'h0000_0204);
        chk("fl_pre", 64'(bus.count), 64'd2);
        bus.in_flight = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_count", 64'(bus.count), 64'd0);
        chk("fl_valid", 64'(bus.out_valid), 64'd0);
        push(32'hDEAD_BEEF, 32'h0000_0300);
        bus.in_flight = 1'b0;
        chk("drop_count", 64'(bus.count), 64'd0);
        push(32'h0000_3003, 32'h0000_0400);
        chk("after_drop_count", 64'(bus.count), 64'd1);
        chk("after_drop_inst", 64'(bus.out_inst), 64'h0000_3003);

        // flush with same-cycle beat and nothing in flight stays in RUN
        bus.flush = 1'b1;
        push(32'h0000_4000, 32'h0000_0500);
        bus.flush = 1'b0;
        chk("flv_count", 64'(bus.count), 64'd0);
        push(32'h0000_4001, 32'h0000_0504);
        chk("flv_next_count", 64'(bus.count), 64'd1);
        chk("flv_next_inst", 64'(bus.out_inst), 64'h0000_4001);

        // flush with same-cycle beat and another in flight enters DROP
        bus.in_flight = 1'b1;
        bus.flush = 1'b1;
        push(32'h0000_5000, 32'h0000_0600);
        bus.flush = 1'b0;
        chk("flvf_count", 64'(bus.count), 64'd0);
        push(32'h0000_5001, 32'h0000_0604);
        bus.in_flight = 1'b0;
        chk("flvf_drop", 64'(bus.count), 64'd0);
        push(32'h0000_5002, 32'h0000_0608);
        chk("flvf_stored", 64'(bus.out_inst), 64'h0000_5002);

        // DROP released by in_flight falling without a beat
        bus.in_flight = 1'b1;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_flight = 1'b0;
        tick();
        push(32'h0000_6000, 32'h0000_0700);
        chk("drop_rel_count", 64'(bus.count), 64'd1);
        chk("drop_rel_inst", 64'(bus.out_inst), 64'h0000_6000);

        // reset wins over a same-cycle flush that would enter DROP
        push(32'h0000_7001, 32'h0000_0800);
        push(32'h0000_7002, 32'h0000_0804);
        chk("r40_pre", 64'(bus.count), 64'd3);
        bus.in_flight = 1'b1;
        bus.flush = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.in_flight = 1'b0;
        chk("r40_count", 64'(bus.count), 64'd0);
        chk("r40_valid", 64'(bus.out_valid), 64'd0);
        push(32'h0000_7003, 32'h0000_0808);
        chk("r40_stored", 64'(bus.count), 64'd1);
        chk("r40_inst", 64'(bus.out_inst), 64'h0000_7003);

        // empty-queue beat with decode ready
        do_reset();
        bus.in_valid  = 1'b1;
        bus.in_inst   = 32'h0000_8001;
        bus.in_pc     = 32'h0000_0900;
        bus.out_ready = 1'b1;
        #1;
`ifdef FETCH_QUEUE_BYPASS_EN
        chk("byp_valid", 64'(bus.out_valid), 64'd1);
        chk("byp_inst", 64'(bus.out_inst), 64'h0000_8001);
        tick();
        idle();
        chk("byp_count", 64'(bus.count), 64'd0);
`else
        chk("nbyp_valid", 64'(bus.out_valid), 64'd0);
        tick();
        idle();
        chk("nbyp_count", 64'(bus.count), 64'd1);
        chk("nbyp_next_valid", 64'(bus.out_valid), 64'd1);
        chk("nbyp_next_inst", 64'(bus.out_inst), 64'h0000_8001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, minimum 2.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  one-cycle pulse: fetched instruction returned this cycle (inst SRAM data_ok).
REQ-005 in_inst  input  32  fetched instruction word.
REQ-006 in_pc  input  32  PC of the fetched instruction.
REQ-007 in_flight  input  1  a fetch request has been accepted and its data is not yet returned.
REQ-008 flush  input  1  branch/exception redirect; discard all queued and pending instructions.
REQ-009 out_ready  input  1  decode stage accepts the head entry this cycle.
REQ-010 out_valid  output  1  head entry valid.
REQ-011 out_inst  output  32  head instruction.
REQ-012 out_pc  output  32  head PC.
REQ-013 count  output  log2(DEPTH)+1  number of occupied entries.
REQ-014 stall_fetch  output  1  high when count >= DEPTH-1; fetch unit SHALL NOT issue new requests.
REQ-015 overflow  output  1  sticky error flag: push attempted while full with no pop.

Function
REQ-016 Storage: DEPTH x 64-bit circular buffer {pc, inst}; wr_ptr and rd_ptr wrap modulo DEPTH.
REQ-017 Push = in_valid and not dropped; pop = out_valid and out_ready.
REQ-018 out_valid = (count != 0); out_inst/out_pc driven from entry rd_ptr; 0 when empty.
REQ-019 Latency: entry pushed in cycle N appears on out_valid at cycle N+1 (no bypass build).
REQ-020 Push and pop in the same cycle: both execute, count unchanged, including when full.
REQ-021 Push while full without pop: data discarded, pointers/count unchanged, overflow set to 1 until reset.
REQ-022 Pop while empty: no effect.
REQ-023 State machine: RUN, DROP. RUN: normal push. DROP: next in_valid is discarded, then return to RUN.
REQ-024 flush in RUN with in_flight=1 and in_valid=0: clear queue, enter DROP.
REQ-025 flush with in_valid=1 same cycle: that beat is discarded; enter DROP only if in_flight remains 1, else stay RUN.
REQ-026 flush in DROP: clear queue, remain DROP.
REQ-027 flush clears count, wr_ptr, rd_ptr in the same edge; flush takes priority over push and pop.
REQ-028 In DROP, in_valid=1 without flush: beat discarded, go to RUN; DROP with in_flight=0 and no in_valid: go to RUN.

Reset
REQ-029 reset SHALL clear count, wr_ptr, rd_ptr, overflow, state=RUN; out_valid=0, out_inst=0, out_pc=0, stall_fetch=0.
REQ-030 reset mid-operation SHALL discard all entries and any pending drop; storage array contents need not be cleared.
REQ-031 reset SHALL take priority over flush, push and pop.

Configuration
REQ-032 Macro FETCH_QUEUE_BYPASS_EN.
REQ-033 Defined: when count==0, state RUN, in_valid=1, flush=0, the input SHALL appear combinationally on out_inst/out_pc with out_valid=1; if out_ready=1 that cycle the beat is consumed and not stored, else it is stored as normal.
REQ-034 Not defined: no combinational path from in_* to out_*; REQ-019 latency holds.

Verification
REQ-035 Push 0x24020001@pc 0xBFC00000, out_ready=0 -> next cycle out_valid=1, out_inst=0x24020001, out_pc=0xBFC00000, count=1.
REQ-036 Push 4 beats, out_ready=0 -> count=4, stall_fetch=1 from count=3; 5th push -> count=4, overflow=1, head unchanged.
REQ-037 Full queue, push and pop same cycle -> count=4, next head = second entry, overflow=0.
REQ-038 count=2, in_flight=1, flush -> count=0 next cycle; next in_valid (inst 0xDEADBEEF) dropped; following in_valid stored, count=1.
REQ-039 Bypass build, empty, in_valid=1, out_ready=1 -> out_valid=1 same cycle, count stays 0; non-bypass build -> count=1, out_valid next cycle.
REQ-040 Assert reset with count=3 and state DROP -> next cycle count=0, out_valid=0, state RUN, first post-reset in_valid stored.
